vga_scan_ctrl: RTL and testbench



---
 rtl/vga_scan_ctrl_if.sv | 25 ++
 rtl/vga_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_ctrl_if.sv
// Line-buffer side of the VGA scan controller: pixel request, colour return
// and the per-pixel invalidate that lets the buffer refill.
interface vga_scan_ctrl_if;
    logic [7:0] x_coord;
    logic [7:0] y_coord;
    logic       invalidate;
    logic       empty;
    logic [7:0] rgb;

    modport master (
        output x_coord,
        output y_coord,
        output invalidate,
        input  empty,
        input  rgb
    );

    modport slave (
        input  x_coord,
        input  y_coord,
        input  invalidate,
        output empty,
        output rgb
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// 640x480@60 raster generator showing a 256x192 line-buffered image at 2x
// scale, centred in a black border; sync and colour leave on the same edge.
module vga_scan_ctrl #(
    parameter int         CLK_DIV         = 4,
    parameter int         H_VISIBLE       = 640,
    parameter int         H_FP            = 16,
    parameter int         H_SYNC          = 96,
    parameter int         H_BP            = 48,
    parameter int         V_VISIBLE       = 480,
    parameter int         V_FP            = 10,
    parameter int         V_SYNC          = 2,
    parameter int         V_BP            = 33,
    parameter int         BORDER_X        = 64,
    parameter int         BORDER_Y        = 48,
    parameter logic [7:0] UNDERFLOW_COLOR = 8'hE0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_scan_ctrl_if.master        lb,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic [2:0]             vga_red,
    output logic [2:0]             vga_green,
    output logic [1:0]             vga_blue,
    output logic                   underflow
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int WIN_W   = 512;
    localparam int WIN_H   = 384;

    logic [DW-1:0] div_cnt;
    logic          pix_en;
    logic          load;
    logic [HW-1:0] h_count;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_count;
    logic [VW-1:0] v_next;
    int            h_off;
    int            v_off;
    int            hn_off;
    int            vn_off;
    logic          active;
    logic          next_active;
    logic          hs_zone;
    logic          vs_zone;
    logic          odd_pair;
    logic [7:0]    pix_color;

    function automatic logic in_window(input int ho, input int vo);
        return (ho >= 0) && (ho < WIN_W) && (vo >= 0) && (vo < WIN_H);
    endfunction

    assign pix_en = (div_cnt == DW'(CLK_DIV - 1));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        h_next = h_count + HW'(1);
        v_next = v_count;
        if (h_count == HW'(H_TOTAL - 1)) begin
            h_next = '0;
            v_next = (v_count == VW'(V_TOTAL - 1)) ? '0 : v_count + VW'(1);
        end
    end

    always_comb begin
        h_off       = int'(h_count) - BORDER_X;
        v_off       = int'(v_count) - BORDER_Y;
        hn_off      = int'(h_next) - BORDER_X;
        vn_off      = int'(v_next) - BORDER_Y;
        active      = in_window(h_off, v_off);
        next_active = in_window(hn_off, vn_off);
        hs_zone     = (int'(h_count) >= H_VISIBLE + H_FP) &&
                      (int'(h_count) <  H_VISIBLE + H_FP + H_SYNC);
        vs_zone     = (int'(v_count) >= V_VISIBLE + V_FP) &&
                      (int'(v_count) <  V_VISIBLE + V_FP + V_SYNC);
        // Second sub-pixel of the second repeat line: the buffer byte is done.
        odd_pair    = h_off[0] & v_off[0];
        pix_color   = 8'h00;
        if (active) begin
            pix_color = lb.empty ? UNDERFLOW_COLOR : lb.rgb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            h_count    <= '0;
            v_count    <= '0;
            lb.x_coord <= 8'h00;
            lb.y_coord <= 8'h00;
            load       <= 1'b0;
        end else begin
            load <= pix_en;
            if (pix_en) begin
                div_cnt <= '0;
                h_count <= h_next;
                v_count <= v_next;
                // Coordinates follow the counters so rgb is ready on load.
                if (next_active) begin
                    lb.x_coord <= 8'(hn_off >> 1);
                    lb.y_coord <= 8'(vn_off >> 1);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hsync     <= 1'b1;
            vga_vsync     <= 1'b1;
            vga_red       <= 3'd0;
            vga_green     <= 3'd0;
            vga_blue      <= 2'd0;
            lb.invalidate <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            lb.invalidate <= 1'b0;
            if (load) begin
                vga_hsync                       <= !hs_zone;
                vga_vsync                       <= !vs_zone;
                {vga_red, vga_green, vga_blue}  <= pix_color;
                lb.invalidate                   <= active && odd_pair && !lb.empty;
                if (active && lb.empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: two instances (divider 4 and 2) with a shortened
// vertical frame, a cycle-count reference model and directed spot checks.
module tb_vga_scan_ctrl;
    localparam int H_TOT = 800;
    localparam int V_TOT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       empty_v [2];
    logic       hs_v    [2];
    logic       vs_v    [2];
    logic       uf_v    [2];
    logic       inv_v   [2];
    logic [7:0] col_v   [2];
    logic [7:0] x_v     [2];
    logic [7:0] y_v     [2];

    logic       hs_a, vs_a, uf_a, hs_b, vs_b, uf_b;
    logic [2:0] r_a, g_a, r_b, g_b;
    logic [1:0] b_a, b_b;

    vga_scan_ctrl_if lb_a ();
    vga_scan_ctrl_if lb_b ();

    assign lb_a.empty = empty_v[0];
    assign lb_b.empty = empty_v[1];
    assign lb_a.rgb   = 8'h5A;
    assign lb_b.rgb   = lb_b.x_coord;

    vga_scan_ctrl #(
        .CLK_DIV(4), .BORDER_Y(1), .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_v[0]), .lb(lb_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a),
        .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a), .underflow(uf_a)
    );

    vga_scan_ctrl #(
        .CLK_DIV(2), .BORDER_Y(1), .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_v[1]), .lb(lb_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b),
        .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b), .underflow(uf_b)
    );

    assign hs_v[0]  = hs_a;           assign hs_v[1]  = hs_b;
    assign vs_v[0]  = vs_a;           assign vs_v[1]  = vs_b;
    assign uf_v[0]  = uf_a;           assign uf_v[1]  = uf_b;
    assign col_v[0] = {r_a, g_a, b_a}; assign col_v[1] = {r_b, g_b, b_b};
    assign inv_v[0] = lb_a.invalidate; assign inv_v[1] = lb_b.invalidate;
    assign x_v[0]   = lb_a.x_coord;   assign x_v[1]   = lb_b.x_coord;
    assign y_v[0]   = lb_a.y_coord;   assign y_v[1]   = lb_b.y_coord;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model: position derived purely from clocks since reset release.
    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction
    function automatic int h_of(input int p);
        return p % H_TOT;
    endfunction
    function automatic int v_of(input int p);
        return (p / H_TOT) % V_TOT;
    endfunction
    function automatic logic win(input int p);
        return h_of(p) >= 64 && h_of(p) < 576 && v_of(p) >= 1 && v_of(p) < 385;
    endfunction
    function automatic logic [7:0] col_of(input int k, input int p, input logic emp);
        if (!win(p)) return 8'h00;
        if (emp)     return 8'hE0;
        return (k == 0) ? 8'h5A : 8'((h_of(p) - 64) >> 1);
    endfunction
    function automatic logic inv_of(input int p, input logic emp);
        return win(p) && ((h_of(p) - 64) % 2 == 1) && ((v_of(p) - 1) % 2 == 1) && !emp;
    endfunction

    int         n_cnt   [2];
    int         inv_cnt [2];
    logic [7:0] e_x [2], e_y [2], e_col [2];
    logic       e_inv [2], e_hs [2], e_vs [2], e_uf [2];

    localparam logic [31:0] RST_VEC = {4'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};

    function automatic logic [31:0] obs_vec(input int k);
        return {4'b0, x_v[k], y_v[k], inv_v[k], hs_v[k], vs_v[k], col_v[k], uf_v[k]};
    endfunction
    function automatic logic [31:0] exp_vec(input int k);
        return {4'b0, e_x[k], e_y[k], e_inv[k], e_hs[k], e_vs[k], e_col[k], e_uf[k]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_v[k]) begin
                n_cnt[k] <= 0;
                e_x[k]   <= 8'h00;
                e_y[k]   <= 8'h00;
                e_inv[k] <= 1'b0;
                e_hs[k]  <= 1'b1;
                e_vs[k]  <= 1'b1;
                e_col[k] <= 8'h00;
                e_uf[k]  <= 1'b0;
            end else begin
                n_cnt[k] <= n_cnt[k] + 1;
                e_inv[k] <= 1'b0;
                if ((n_cnt[k] + 1) % div_of(k) == 0 && win((n_cnt[k] + 1) / div_of(k))) begin
                    e_x[k] <= 8'((h_of((n_cnt[k] + 1) / div_of(k)) - 64) >> 1);
                    e_y[k] <= 8'((v_of((n_cnt[k] + 1) / div_of(k)) - 1) >> 1);
                end
                if (n_cnt[k] > 0 && n_cnt[k] % div_of(k) == 0) begin
                    e_hs[k]  <= !(h_of(n_cnt[k] / div_of(k)) >= 656 && h_of(n_cnt[k] / div_of(k)) < 752);
                    e_vs[k]  <= !(v_of(n_cnt[k] / div_of(k)) >= 5 && v_of(n_cnt[k] / div_of(k)) < 7);
                    e_col[k] <= col_of(k, n_cnt[k] / div_of(k), empty_v[k]);
                    e_inv[k] <= inv_of(n_cnt[k] / div_of(k), empty_v[k]);
                    if (win(n_cnt[k] / div_of(k)) && empty_v[k]) e_uf[k] <= 1'b1;
                end
            end
        end
    end

    // Per-clock comparison against the model plus first-frame invalidate count.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k] && n_cnt[k] > 0) begin
                check((k == 0) ? "mon_a" : "mon_b", obs_vec(k), exp_vec(k));
                if (inv_v[k] && n_cnt[k] <= H_TOT * V_TOT * div_of(k))
                    inv_cnt[k] <= inv_cnt[k] + 1;
            end
        end
    end

    task automatic wait_n(input int k, input int target);
        int guard = 0;
        while (n_cnt[k] < target && guard < 60000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (n_cnt[k] != target) check("wait_n", n_cnt[k], target);
    endtask

    task automatic wait_sig(input int k, input bit sel_vs, input logic lvl,
                            input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((sel_vs ? vs_v[k] : hs_v[k]) == lvl) begin
                at = n_cnt[k];
                break;
            end
        end
    endtask

    task automatic run_a();
        int f1, r1, f2, vf, vr;
        wait_sig(0, 1'b0, 1'b0, 3000, f1);
        check("a_hs_fall", f1, 2625);
        wait_sig(0, 1'b0, 1'b1, 1000, r1);
        check("a_hs_low", r1 - f1, 384);
        wait_n(0, 3461);                     // v=1 h=65: first repeat line
        check("a_inv_rep1", inv_v[0], 1'b0);
        wait_sig(0, 1'b0, 1'b0, 4000, f2);
        check("a_line", f2 - f1, 3200);
        wait_n(0, 6653);  check("a_col_h63", col_v[0], 8'h00);
        wait_n(0, 6657);  check("a_col_h64", col_v[0], 8'h5A);
        wait_n(0, 6661);  check("a_inv_h65", inv_v[0], 1'b1);
        wait_n(0, 6662);  check("a_inv_w1", inv_v[0], 1'b0);
        wait_n(0, 6665);  check("a_inv_h66", inv_v[0], 1'b0);
        wait_n(0, 8701);  check("a_col_h575", col_v[0], 8'h5A);
        wait_n(0, 8705);  check("a_col_h576", col_v[0], 8'h00);
        wait_sig(0, 1'b1, 1'b0, 20000, vf);
        check("a_vs_fall", vf, 16001);
        wait_sig(0, 1'b1, 1'b1, 10000, vr);
        check("a_vs_low", vr - vf, 6400);
        wait_n(0, 25600);
        check("a_inv_frame", inv_cnt[0], 768);
        check("a_uf_clear", uf_v[0], 1'b0);
        // Empty for 10 clks on frame 2, v=4, starting just before h=200.
        wait_n(0, 39198);
        empty_v[0] = 1'b1;
        wait_n(0, 39201); check("a_col_empty", col_v[0], 8'hE0);
        check("a_uf_set", uf_v[0], 1'b1);
        wait_n(0, 39205); check("a_inv_empty", inv_v[0], 1'b0);
        wait_n(0, 39208);
        empty_v[0] = 1'b0;
        wait_n(0, 39209); check("a_col_refill", col_v[0], 8'h5A);
        check("a_uf_sticky", uf_v[0], 1'b1);
        wait_n(0, 39213); check("a_inv_resume", inv_v[0], 1'b1);
        wait_n(0, 40000);
        @(negedge clk);
        rst_v[0] = 1'b0;
        #1;
        check("a_async_rst", obs_vec(0), RST_VEC);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b1;
        wait_sig(0, 1'b0, 1'b0, 3000, f1);
        check("a_rst_hs_fall", f1, 2625);
    endtask

    task automatic run_b();
        int f1, r1, f2;
        wait_sig(1, 1'b0, 1'b0, 2000, f1);
        check("b_hs_fall", f1, 1313);
        wait_sig(1, 1'b0, 1'b1, 500, r1);
        check("b_hs_low", r1 - f1, 192);
        wait_sig(1, 1'b0, 1'b0, 2000, f2);
        check("b_line", f2 - f1, 1600);
        wait_n(1, 3329); check("b_col_h64", col_v[1], 8'h00);
        wait_n(1, 3331); check("b_col_h65", col_v[1], 8'h00);
        wait_n(1, 3332); check("b_x_h66", x_v[1], 8'd1);
        check("b_col_hold", col_v[1], 8'h00);
        wait_n(1, 3333); check("b_col_h66", col_v[1], 8'h01);
        wait_n(1, 4351); check("b_col_h575", col_v[1], 8'hFF);
        wait_n(1, 4353); check("b_col_h576", col_v[1], 8'h00);
        wait_n(1, 12800);
        check("b_inv_frame", inv_cnt[1], 768);
    endtask

    initial begin
        rst_v[0]   = 1'b0;
        rst_v[1]   = 1'b0;
        empty_v[0] = 1'b0;
        empty_v[1] = 1'b0;
        inv_cnt[0] = 0;
        inv_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset", obs_vec(0), RST_VEC);
        check("b_reset", obs_vec(1), RST_VEC);
        @(negedge clk);
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
